// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: 4 byte reads per word, word on is_out 5 cycles after B0; stall_in freezes outputs, a finished word parks in a 1-entry hold buffer.
// Define INST_FETCH_ICACHE_EN to add a 32-line direct-mapped word cache looked up in B0.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        jump_en,
  input  logic [31:0] jump_pc,
  input  logic        mem_busy,
  input  logic [7:0]  mem_din,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] pc_out,
  output logic [31:0] is_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_B0   = 3'd1;
  localparam logic [2:0] S_B1   = 3'd2;
  localparam logic [2:0] S_B2   = 3'd3;
  localparam logic [2:0] S_B3   = 3'd4;
  localparam logic [2:0] S_WAIT = 3'd5;

  logic [2:0]  state, state_nxt;
  logic [31:0] fpc;
  logic [7:0]  byte0, byte1, byte2;
  logic        hold_vld;
  logic [31:0] hold_word;
  logic        in_byte;
  logic [1:0]  byte_ofs;
  logic [31:0] fetch_word;
  logic        cache_hit;
  logic [31:0] cache_word;
  logic        word_done;
  logic [31:0] done_word;
  logic        deliver;
  logic [31:0] deliver_word;
  logic        park;

  assign fetch_word = {mem_din, byte2, byte1, byte0};

`ifdef INST_FETCH_ICACHE_EN
  logic [31:0] line_vld;
  logic [24:0] line_tag  [32];
  logic [31:0] line_data [32];
  logic [4:0]  line_idx;
  logic        fill;

  assign line_idx   = fpc[6:2];
  assign cache_hit  = (state == S_B0) && line_vld[line_idx] && (line_tag[line_idx] == fpc[31:7]);
  assign cache_word = line_data[line_idx];
  // A word discarded by a jump is not cached either.
  assign fill       = (state == S_WAIT) && !jump_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      line_vld <= '0;
    end else if (fill) begin
      line_vld[line_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      line_tag[line_idx]  <= fpc[31:7];
      line_data[line_idx] <= fetch_word;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_word = 32'h0;
`endif

  always_comb begin
    in_byte  = 1'b0;
    byte_ofs = 2'd0;
    case (state)
      S_B0: in_byte = 1'b1;
      S_B1: begin in_byte = 1'b1; byte_ofs = 2'd1; end
      S_B2: begin in_byte = 1'b1; byte_ofs = 2'd2; end
      S_B3: begin in_byte = 1'b1; byte_ofs = 2'd3; end
      default: ;
    endcase
  end

  assign mem_req  = in_byte && !mem_busy && !cache_hit;
  assign mem_addr = fpc + {30'd0, byte_ofs};

  assign word_done    = (state == S_WAIT) || cache_hit;
  assign done_word    = cache_hit ? cache_word : fetch_word;
  assign deliver      = !stall_in && (((state == S_IDLE) && hold_vld) || word_done);
  assign deliver_word = hold_vld ? hold_word : done_word;
  assign park         = stall_in && word_done;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (!hold_vld || !stall_in) state_nxt = S_B0;
      S_B0: begin
        if (cache_hit)      state_nxt = stall_in ? S_IDLE : S_B0;
        else if (!mem_busy) state_nxt = S_B1;
      end
      // A busy memory port throws away the partial word; refetch from byte 0.
      S_B1:   state_nxt = mem_busy ? S_B0 : S_B2;
      S_B2:   state_nxt = mem_busy ? S_B0 : S_B3;
      S_B3:   state_nxt = mem_busy ? S_B0 : S_WAIT;
      S_WAIT: state_nxt = stall_in ? S_IDLE : S_B0;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      fpc       <= 32'h0;
      pc_out    <= 32'h0;
      is_out    <= 32'h0;
      hold_vld  <= 1'b0;
      hold_word <= 32'h0;
      byte0     <= 8'h0;
      byte1     <= 8'h0;
      byte2     <= 8'h0;
    end else if (jump_en) begin
      state    <= S_B0;
      fpc      <= jump_pc;
      hold_vld <= 1'b0;
      is_out   <= 32'h0;
    end else begin
      state <= state_nxt;
      if (deliver) begin
        fpc    <= fpc + 32'd4;
        pc_out <= fpc + 32'd4;
      end
      if (!stall_in) is_out <= deliver ? deliver_word : 32'h0;
      if (park) begin
        hold_vld  <= 1'b1;
        hold_word <= done_word;
      end else if (deliver && hold_vld) begin
        hold_vld <= 1'b0;
      end
      case (state)
        S_B1: byte0 <= mem_din;
        S_B2: byte1 <= mem_din;
        S_B3: byte2 <= mem_din;
        default: ;
      endcase
    end
  end

endmodule
